// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetches one 16-bit instruction per step from instruction memory over a
//   req/ack handshake, decodes jump/branch/halt, evaluates branch conditions
//   against the ALU flags, and releases exactly one PC advance per instruction.
//
// Ports
//   clk_pi, reset_pi       clock (rising edge) and asynchronous active-high reset
//   pc_pi                  current program counter value
//   resume_pi              leave HALTED (level, looked at only while halted)
//   imem_req_po/addr_po    fetch request and address (address stable during req)
//   imem_ack_pi/data_pi    memory acknowledge and instruction word
//   flags_pi/flags_valid_pi  {Z,N,C} and their validity for branch evaluation
//   pc_clk_en_po           one-cycle PC advance strobe
//   branch_taken_po/branch_immediate_po, jump_taken_po/jump_immediate_po
//                          PC control, meaningful only with pc_clk_en_po
//   instr_po/instr_valid_po  latched instruction and its completion strobe
//   halted_po, fetch_error_po  halted state and sticky fetch-timeout flag
module fetch_sequencer #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_W      = 8,
  parameter logic [3:0]  HALT_OPCODE    = 4'hF
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic [15:0] pc_pi,
  input  logic        resume_pi,
  output logic        imem_req_po,
  output logic [15:0] imem_addr_po,
  input  logic        imem_ack_pi,
  input  logic [15:0] imem_data_pi,
  input  logic [2:0]  flags_pi,
  input  logic        flags_valid_pi,
  output logic        pc_clk_en_po,
  output logic        branch_taken_po,
  output logic [5:0]  branch_immediate_po,
  output logic        jump_taken_po,
  output logic [11:0] jump_immediate_po,
  output logic [15:0] instr_po,
  output logic        instr_valid_po,
  output logic        halted_po,
  output logic        fetch_error_po
);

  // SETUP is the bubble after a redirect (taken branch/jump, resume from
  // halt): the PC has just been updated, so the new address is captured
  // from pc_pi one cycle later with no request outstanding.
  typedef enum logic [2:0] {IDLE, REQ, EXEC, SETUP, HALTED} state_t;

  localparam logic [TIMEOUT_W-1:0] COUNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [15:0]            addr_reg, addr_next;
  logic [15:0]            instr_reg, instr_next;
  logic [TIMEOUT_W-1:0]   count_reg, count_next;
  logic                   error_reg, error_next;

  logic [3:0] opcode;
  logic       is_halt, is_branch, is_jump, cond_true, redirect;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      instr_reg <= '0;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      instr_reg <= instr_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  assign opcode    = instr_reg[15:12];
  // Halt is checked first so HALT_OPCODE wins even if set to a jump/branch code.
  assign is_halt   = (opcode == HALT_OPCODE);
  assign is_jump   = !is_halt && (opcode == 4'hE);
  assign is_branch = !is_halt && (opcode == 4'hD);

  // flags_pi = {Z,N,C}
  always_comb begin
    cond_true = 1'b0;
    case (instr_reg[8:6])
      3'b000: cond_true =  flags_pi[2];
      3'b001: cond_true = !flags_pi[2];
      3'b010: cond_true =  flags_pi[1];
      3'b011: cond_true = !flags_pi[1];
      3'b100: cond_true =  flags_pi[0];
      3'b101: cond_true = !flags_pi[0];
      3'b110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    instr_next      = instr_reg;
    count_next      = count_reg;
    error_next      = error_reg;
    imem_req_po     = 1'b0;
    pc_clk_en_po    = 1'b0;
    branch_taken_po = 1'b0;
    jump_taken_po   = 1'b0;
    instr_valid_po  = 1'b0;
    halted_po       = 1'b0;
    redirect        = 1'b0;

    case (state_reg)
      IDLE: begin
        addr_next  = pc_pi;
        state_next = REQ;
      end

      REQ: begin
        imem_req_po = 1'b1;
        if (imem_ack_pi) begin
          instr_next = imem_data_pi;
          count_next = '0;
          state_next = EXEC;
        end else if (count_reg == COUNT_LAST) begin
          error_next = 1'b1;
          count_next = '0;
          state_next = HALTED;
        end else begin
          count_next = count_reg + TIMEOUT_W'(1);
        end
      end

      EXEC: begin
        if (is_halt) begin
          state_next = HALTED;
        end else if (is_branch && !flags_valid_pi) begin
          state_next = EXEC;  // wait for flags covering older instructions
        end else begin
          pc_clk_en_po    = 1'b1;
          instr_valid_po  = 1'b1;
          branch_taken_po = is_branch && cond_true;
          jump_taken_po   = is_jump;
          redirect        = (is_branch && cond_true) || is_jump;
          if (redirect) begin
            state_next = SETUP;
          end else begin
            // pc_pi still holds the old PC this cycle; it advances by 2 at the edge.
            addr_next  = pc_pi + 16'd2;
            state_next = REQ;
          end
        end
      end

      SETUP: begin
        addr_next  = pc_pi;
        state_next = REQ;
      end

      HALTED: begin
        halted_po = 1'b1;
        if (resume_pi) begin
          if (error_reg) begin
            // Retry the failed fetch at the same address; PC untouched.
            error_next = 1'b0;
            state_next = REQ;
          end else begin
            // Step past the halt instruction with a plain sequential advance.
            pc_clk_en_po = 1'b1;
            state_next   = SETUP;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign imem_addr_po        = addr_reg;
  assign instr_po            = instr_reg;
  assign branch_immediate_po = instr_reg[5:0];
  assign jump_immediate_po   = instr_reg[11:0];
  assign fetch_error_po      = error_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        resume = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [2:0]  flags = 3'b000;
  logic        fv = 1'b0;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        pc_clk_en, branch_taken, jump_taken, instr_valid, halted, fetch_error;
  logic [5:0]  branch_imm;
  logic [11:0] jump_imm;
  logic [15:0] instr;

  fetch_sequencer #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8), .HALT_OPCODE(4'hF)) dut (
    .clk_pi(clk), .reset_pi(rst), .pc_pi(pc), .resume_pi(resume),
    .imem_req_po(imem_req), .imem_addr_po(imem_addr),
    .imem_ack_pi(ack), .imem_data_pi(data),
    .flags_pi(flags), .flags_valid_pi(fv),
    .pc_clk_en_po(pc_clk_en), .branch_taken_po(branch_taken),
    .branch_immediate_po(branch_imm), .jump_taken_po(jump_taken),
    .jump_immediate_po(jump_imm), .instr_po(instr), .instr_valid_po(instr_valid),
    .halted_po(halted), .fetch_error_po(fetch_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_addr = 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch condition table, flags = {Z,N,C}
  function automatic logic cond_model(input logic [2:0] c, input logic [2:0] f);
    case (c)
      3'd0: return f[2];
      3'd1: return !f[2];
      3'd2: return f[1];
      3'd3: return !f[1];
      3'd4: return f[0];
      3'd5: return !f[0];
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_pcen"}, pc_clk_en, 0);
    chk({tag, "_taken"}, {branch_taken, jump_taken}, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err"}, fetch_error, 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("req_seen", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_addr);
  endtask

  task automatic fetch(input logic [15:0] word, input int lat);
    wait_req();
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, exp_addr);
    end
    ack = 1'b1;
    data = word;
    tick();
    ack = 1'b0;
    data = 16'($urandom);
  endtask

  task automatic exec(input logic [15:0] word, input logic [2:0] fl, input int stall);
    logic is_h, is_br, is_j, tk;
    logic [15:0] npc;
    is_h  = (word[15:12] == 4'hF);
    is_br = (word[15:12] == 4'hD);
    is_j  = (word[15:12] == 4'hE);
    flags = fl;
    chk("instr_latched", instr, word);
    if (is_h) begin
      fv = 1'($urandom);
      #1;
      chk("halt_no_pcen", pc_clk_en, 0);
      chk("halt_no_valid", instr_valid, 0);
      tick();
      chk("halted", halted, 1);
      chk("halt_no_req", imem_req, 0);
      return;
    end
    if (is_br) begin
      fv = 1'b0;
      for (int i = 0; i < stall; i++) begin
        #1;
        chk("stall_no_pcen", pc_clk_en, 0);
        tick();
      end
      fv = 1'b1;
    end else begin
      fv = 1'($urandom);
    end
    #1;
    tk = is_br && cond_model(word[8:6], fl);
    $display("[TB] instr=%h flags=%b pc=%h taken_br=%0d jump=%0d", word, fl, pc, tk, is_j);
    chk("fire_pcen", pc_clk_en, 1);
    chk("fire_valid", instr_valid, 1);
    chk("branch_taken", branch_taken, tk);
    chk("jump_taken", jump_taken, is_j);
    chk("branch_imm", branch_imm, word[5:0]);
    chk("jump_imm", jump_imm, word[11:0]);
    if (is_j)      npc = {3'b000, word[11:0], 1'b0};
    else if (tk)   npc = pc + {{9{word[5]}}, word[5:0], 1'b0};
    else           npc = pc + 16'd2;
    tick();
    pc = npc;
    exp_addr = npc;
    fv = 1'b0;
    chk("no_double_pcen", pc_clk_en, 0);
    if (tk || is_j) chk("setup_no_req", imem_req, 0);
  endtask

  task automatic halt_resume(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("hold_halted", halted, 1);
      chk("hold_no_pcen", pc_clk_en, 0);
      tick();
    end
    resume = 1'b1;
    #1;
    chk("resume_pcen", pc_clk_en, 1);
    chk("resume_taken", {branch_taken, jump_taken}, 0);
    chk("resume_valid", instr_valid, 0);
    tick();
    resume = 1'b0;
    pc = pc + 16'd2;
    exp_addr = pc;
    chk("resume_unhalted", halted, 0);
    chk("resume_setup_no_req", imem_req, 0);
    chk("resume_no_double", pc_clk_en, 0);
  endtask

  task automatic timeout_case();
    wait_req();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", imem_req, 1);
      tick();
    end
    chk("to_error", fetch_error, 1);
    chk("to_halted", halted, 1);
    chk("to_no_req", imem_req, 0);
    chk("to_no_pcen", pc_clk_en, 0);
    tick();
    chk("to_error_sticky", fetch_error, 1);
    resume = 1'b1;
    #1;
    chk("to_resume_no_pcen", pc_clk_en, 0);
    tick();
    resume = 1'b0;
    chk("to_error_clr", fetch_error, 0);
    chk("to_rereq", imem_req, 1);
    chk("to_same_addr", imem_addr, exp_addr);
    $display("[TB] timeout at addr=%h handled", exp_addr);
  endtask

  task automatic random_instr();
    int kind;
    logic [15:0] w;
    kind = $urandom_range(0, 9);
    if (kind < 4)      w = {4'($urandom_range(0, 12)), 12'($urandom)};
    else if (kind < 7) w = {4'hD, 12'($urandom)};
    else if (kind < 9) w = {4'hE, 12'($urandom)};
    else               w = {4'hF, 12'($urandom)};
    fetch(w, $urandom_range(0, 2));
    exec(w, 3'($urandom), $urandom_range(0, 3));
    if (w[15:12] == 4'hF) halt_resume($urandom_range(0, 3));
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    exp_addr = 16'h0000;

    fetch(16'h1234, 0);
    exec(16'h1234, 3'b000, 0);
    chk("seq_next_addr", exp_addr, 16'h0002);
    fetch(16'hE7FE, 1);
    exec(16'hE7FE, 3'b000, 0);
    fetch(16'hD03C, 0);
    exec(16'hD03C, 3'b100, 3);
    fetch(16'hD03C, 2);
    exec(16'hD03C, 3'b011, 0);
    fetch(16'hF000, 0);
    exec(16'hF000, 3'b000, 0);
    halt_resume(5);
    timeout_case();
    fetch(16'h0042, 0);
    exec(16'h0042, 3'b000, 0);

    for (int i = 0; i < 40; i++) random_instr();

    // Reset in the middle of a request cycle, with an ack arriving while reset is held.
    wait_req();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    ack = 1'b1;
    data = 16'hE123;
    tick();
    tick();
    check_all_zero("rst_held");
    ack = 1'b0;
    #2;
    rst = 1'b0;
    exp_addr = pc;
    $display("[TB] mid-request reset released, restart at %h", pc);

    for (int i = 0; i < 15; i++) random_instr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program counter's control inputs: clock enable, branch-taken / branch immediate, jump-taken / jump immediate.
- Fetches each 16-bit instruction word at the current PC from instruction memory over a req/ack handshake, then decodes branch/jump/halt.
- Evaluates branch conditions against ALU flags, then releases exactly one PC advance per instruction.
- Sits between the program counter, instruction memory and the decode/execute stage.

Parameters:
TIMEOUT_CYCLES, 255, cycles REQ may wait for imem_ack_pi before a fetch error (1..2^TIMEOUT_W-1)
TIMEOUT_W, 8, width of timeout counter
HALT_OPCODE, 4'hF, instr[15:12] value that halts the sequencer

Ports:
clk_pi  in  1  clock, all state on rising edge
reset_pi  in  1  asynchronous, active-high reset
pc_pi  in  16  current PC from program counter
resume_pi  in  1  leave HALTED (level, sampled in HALTED only)
imem_req_po  out  1  fetch request, held until ack
imem_addr_po  out  16  fetch address, stable while imem_req_po=1
imem_ack_pi  in  1  data valid this cycle (sampled only while imem_req_po=1)
imem_data_pi  in  16  instruction word
flags_pi  in  3  {Z,N,C} from ALU
flags_valid_pi  in  1  flags reflect all older instructions
pc_clk_en_po  out  1  one-cycle PC advance strobe
branch_taken_po  out  1  valid only with pc_clk_en_po
branch_immediate_po  out  6  instr[5:0], unextended
jump_taken_po  out  1  valid only with pc_clk_en_po
jump_immediate_po  out  12  instr[11:0], unextended
instr_po  out  16  latched instruction
instr_valid_po  out  1  high with pc_clk_en_po for non-halt instructions
halted_po  out  1  in HALTED state
fetch_error_po  out  1  sticky timeout flag

Behaviour:
- Reset (async): state IDLE. instr reg=0, timeout counter=0. All outputs 0, incl. imem_req_po (drops immediately, mid-handshake too). Pending ack discarded.
- States: IDLE, REQ, EXEC, HALTED.
- IDLE: next edge after reset deasserts -> REQ; imem_addr_po <= pc_pi.
- REQ: imem_req_po=1; address held.
  - imem_ack_pi=1: instr <= imem_data_pi, counter cleared -> EXEC. Ack allowed in first REQ cycle, giving 1-cycle fetch.
  - No ack: counter increments. When counter==TIMEOUT_CYCLES-1 and no ack: fetch_error_po<=1, -> HALTED, no PC advance.
- EXEC decode on instr:
  - Jump: instr[15:12]=4'hE.
  - Branch: instr[15:12]=4'hD; cond=instr[8:6], imm=instr[5:0].
  - Halt: instr[15:12]=HALT_OPCODE.
  - Anything else: sequential.
- Branch conditions: 000 Z; 001 !Z; 010 N; 011 !N; 100 C; 101 !C; 110 always; 111 never.
- EXEC fire: single cycle. pc_clk_en_po=1, instr_valid_po=1. branch_taken_po=branch&&cond_true; jump_taken_po=jump. -> REQ, imem_addr_po <= pc_pi + 2 (PC value after a sequential advance). For taken branch/jump the address is instead loaded from pc_pi on the cycle after the fire cycle: the sequencer inserts one REQ-setup cycle with imem_req_po=0.
- Branch with flags_valid_pi=0: stay in EXEC, pc_clk_en_po=0, re-evaluate each cycle. Flags sampled in the fire cycle only. Non-branch instructions ignore flags_valid_pi.
- Halt: no pc_clk_en_po; -> HALTED, halted_po=1, instr_valid_po=0.
- HALTED:
  - resume_pi=1 after a halt instruction: pulse pc_clk_en_po (sequential, taken flags 0), -> setup cycle, then REQ at new pc_pi.
  - resume_pi=1 after fetch error: clear fetch_error_po, -> REQ at same address, no PC advance.
- Invariant: branch_taken_po and jump_taken_po never 1 in the same cycle. Neither is 1 without pc_clk_en_po.
- Exactly one pc_clk_en_po pulse per completed instruction; never two in consecutive cycles.

Test Plan:
- Reset then pc_pi=0, mem returns 16'h1234 with ack in first REQ cycle -> imem_addr_po=0; next cycle pc_clk_en_po=1, instr_valid_po=1, no taken; next imem_addr_po=2.
- instr 16'hE7FE (jump, imm 12'h7FE) -> one cycle: pc_clk_en_po=1, jump_taken_po=1, jump_immediate_po=12'h7FE; one idle cycle; then fetch from new pc_pi.
- instr 16'hD03C (cond 000, imm 6'h3C), flags_valid_pi=0 for 3 cycles then 1 with Z=1 -> 3 stall cycles with pc_clk_en_po=0, then branch_taken_po=1, branch_immediate_po=6'h3C. Repeat with Z=0 -> sequential.
- instr 16'hF000 -> halted_po=1, no PC pulse; hold 5 cycles; resume_pi=1 -> single pc_clk_en_po, halted_po=0, fetch resumes.
- TIMEOUT_CYCLES=4, ack never -> fetch_error_po=1 and halted_po=1 after 4 REQ cycles; resume_pi -> error clears, re-request same address.
- Assert reset_pi mid-REQ (between clock edges) -> imem_req_po falls immediately; all outputs 0; late ack ignored; restart from IDLE.
